wb_stage_buffered: RTL

- Parametrised writeback stage. Sits between the memory stage and the register-file write port.
- Selects the ALU result or the memory load data, and applies load-width extension.
- Queues the formatted writes in a small FIFO. Drains one write per cycle to the register file, whenever the register file's write port is not busy.
- Tells the hazard unit which registers have writes still pending, so the hazard unit can stall or forward.

---
 rtl/wb_stage_buffered.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_stage_buffered.sv
// wb_stage_buffered: writeback stage with a small write queue.
//   Formats the writeback value (ALU result or extended load data), queues register writes
//   in a DEPTH-entry FIFO and drains one write per cycle into a registered output stage
//   whenever the register-file write port is free.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_*              op from the memory stage (valid/ready handshake)
//   rf_busy           register-file write port unavailable this cycle
//   reg_write_*       registered register-file write (en pulses for one cycle per write)
//   wb_op_dest        copy of reg_write_dest for the hazard unit
//   pend_mask         one-hot OR of every queued / in-flight destination
//   q_count           number of occupied queue entries
module wb_stage_buffered #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned REG_AW        = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ZERO_SUPPRESS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_alu_data,
  input  logic [DATA_W-1:0]          in_mem_data,
  input  logic                       in_mem_sel,
  input  logic [1:0]                 in_ld_mode,
  input  logic                       in_wr_en,
  input  logic [REG_AW-1:0]          in_dest,
  input  logic                       rf_busy,
  output logic                       reg_write_en,
  output logic [REG_AW-1:0]          reg_write_dest,
  output logic [DATA_W-1:0]          reg_write_data,
  output logic [REG_AW-1:0]          wb_op_dest,
  output logic [(1<<REG_AW)-1:0]     pend_mask,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 1 << REG_AW;
  localparam int unsigned H       = DATA_W / 2;

  logic [REG_AW-1:0] mem_dest_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0] fmt_data;
  logic              store;
  logic              push;
  logic              pop;

  // Writeback value formatting
  always_comb begin
    fmt_data = in_alu_data;
    if (in_mem_sel) begin
      unique case (in_ld_mode)
        2'b00:   fmt_data = in_mem_data;
        2'b01:   fmt_data = {{H{in_mem_data[H-1]}}, in_mem_data[H-1:0]};
        2'b10:   fmt_data = {{H{1'b0}}, in_mem_data[H-1:0]};
        default: fmt_data = {{H{1'b0}}, in_mem_data[DATA_W-1:H]};
      endcase
    end
  end

  // Readiness depends only on occupancy; a same-cycle pop never frees a slot early.
  assign in_ready = (count_q != CntW'(DEPTH));
  assign store    = in_wr_en && !((ZERO_SUPPRESS != 0) && (in_dest == '0));
  assign push     = in_valid && in_ready && store;
  assign pop      = (count_q != '0) && !rf_busy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wen_d    = 1'b0;
    dest_d   = dest_q;
    data_d   = data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      wen_d    = 1'b1;
      dest_d   = mem_dest_q[rd_ptr_q];
      data_d   = mem_data_q[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
    end
  end

  // Payload storage needs no reset: an entry is only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest_q[wr_ptr_q] <= in_dest;
      mem_data_q[wr_ptr_q] <= fmt_data;
    end
  end

  // Pending destinations: occupied entries are the count_q slots starting at rd_ptr_q.
  always_comb begin
    logic [PtrW-1:0] idx;
    pend_mask = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        pend_mask[mem_dest_q[idx]] = 1'b1;
      end
    end
    if (wen_q) begin
      pend_mask[dest_q] = 1'b1;
    end
  end

  assign reg_write_en   = wen_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign wb_op_dest     = dest_q;
  assign q_count        = count_q;

  logic unused_num_regs;
  assign unused_num_regs = (NumRegs == 0);

endmodule
